// File: rtl/dmem_resp_wires.sv
// Shared types for the dmem_resp data-memory responder: bus records, RAM port records,
// controller state and register record.
package dmem_resp_wires;

    localparam int unsigned RamAddrW = 30;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic        mem_fence;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    // addr is sized for the largest array; the RAM uses the low DEPTH bits
    typedef struct packed {
        logic                wen;
        logic [3:0]          wstrb;
        logic [RamAddrW-1:0] addr;
        logic [31:0]         wdata;
    } dmem_resp_ram_in_type;

    typedef struct packed {
        logic [31:0] rdata;
    } dmem_resp_ram_out_type;

    typedef struct packed {
        state_t      state;
        logic [7:0]  cnt;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        fence;
        logic        ready;
        logic [31:0] rdata;
        logic        seq_valid;
        logic [31:0] seq_addr;
    } dmem_resp_reg_type;

    localparam dmem_resp_reg_type init_reg = '{
        state:     StIdle,
        cnt:       8'd0,
        addr:      32'd0,
        wdata:     32'd0,
        wstrb:     4'd0,
        fence:     1'b0,
        ready:     1'b0,
        rdata:     32'd0,
        seq_valid: 1'b0,
        seq_addr:  32'd0
    };

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_resp_ram.sv
// Word array with byte-strobed synchronous write and combinational read.
module dmem_resp_ram
    import dmem_resp_wires::*;
#(
    parameter int unsigned DEPTH = 10
) (
    input  logic                  clk,
    input  dmem_resp_ram_in_type  ram_in,
    output dmem_resp_ram_out_type ram_out
);

    logic [31:0]      mem [2**DEPTH];
    logic [DEPTH-1:0] idx;

    assign idx = ram_in.addr[DEPTH-1:0];

    if (DEPTH < RamAddrW) begin : g_unused_addr
        logic unused_addr;
        assign unused_addr = ^ram_in.addr[RamAddrW-1:DEPTH];
    end

    always_ff @(posedge clk) begin
        if (ram_in.wen) mem[idx] <= merge_bytes(mem[idx], ram_in.wdata, ram_in.wstrb);
    end

    assign ram_out.rdata = mem[idx];

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder with programmable wait states backed by dmem_resp_ram.
// Optional sequential-read fast path enabled by `define DMEM_RESP_SEQ_EN.
module dmem_resp
    import dmem_resp_wires::*;
#(
    parameter int unsigned DEPTH     = 10,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  mem_in_type  mem_in,
    output mem_out_type mem_out
);

    localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + (33'd4 << DEPTH);
    localparam logic [7:0]  CNT_INIT = 8'(LATENCY);

    dmem_resp_reg_type     r, rin, v;
    dmem_resp_ram_in_type  ram_in;
    dmem_resp_ram_out_type ram_out;

    logic        acc_go;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_wstrb;
    logic        acc_fence;
    logic        in_range;
    logic        is_read;
    logic        seq_hit;
    logic        unused_in;

    assign unused_in = mem_in.mem_instr;

    // With zero wait states the access happens in the IDLE cycle, straight off the bus
    always_comb begin
        acc_addr  = r.addr;
        acc_wdata = r.wdata;
        acc_wstrb = r.wstrb;
        acc_fence = r.fence;
        if (r.state == StIdle) begin
            acc_addr  = mem_in.mem_addr;
            acc_wdata = mem_in.mem_wdata;
            acc_wstrb = mem_in.mem_wstrb;
            acc_fence = mem_in.mem_fence;
        end
    end

    assign in_range = (acc_addr >= BASE_ADDR) && ({1'b0, acc_addr} < LIMIT);
    assign is_read  = (acc_wstrb == 4'h0) && !acc_fence;

`ifdef DMEM_RESP_SEQ_EN
    assign seq_hit = r.seq_valid && is_read && in_range &&
                     (mem_in.mem_addr == r.seq_addr + 32'd4);
`else
    assign seq_hit = 1'b0;
`endif

    always_comb begin
        v       = r;
        acc_go  = 1'b0;
        v.ready = 1'b0;
        v.rdata = '0;
        unique case (r.state)
            StIdle: begin
                if (mem_in.mem_valid) begin
                    v.addr  = mem_in.mem_addr;
                    v.wdata = mem_in.mem_wdata;
                    v.wstrb = mem_in.mem_wstrb;
                    v.fence = mem_in.mem_fence;
                    v.cnt   = CNT_INIT;
                    v.state = StWait;
                    acc_go  = (LATENCY == 0) || mem_in.mem_fence || seq_hit;
                end
`ifdef DMEM_RESP_SEQ_EN
                // An idle gap breaks the back-to-back chain
                if (!mem_in.mem_valid) v.seq_valid = 1'b0;
`endif
            end
            StWait: begin
                v.cnt  = r.cnt - 8'd1;
                acc_go = (r.cnt <= 8'd1);
            end
            StResp: v.state = StIdle;
            default: v.state = StIdle;
        endcase
        if (acc_go) begin
            v.state = StResp;
            v.cnt   = '0;
            v.ready = 1'b1;
            v.rdata = (is_read && in_range) ? ram_out.rdata : '0;
`ifdef DMEM_RESP_SEQ_EN
            v.seq_valid = is_read && in_range;
            v.seq_addr  = acc_addr;
`endif
        end
        rin = v;
    end

    // rst gates the write so nothing lands in the array while reset is held
    always_comb begin
        ram_in.wen   = acc_go && !acc_fence && (|acc_wstrb) && in_range && !rst;
        ram_in.wstrb = acc_wstrb;
        ram_in.addr  = RamAddrW'(acc_addr[DEPTH+1:2]);
        ram_in.wdata = acc_wdata;
    end

    dmem_resp_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clk    (clk),
        .ram_in (ram_in),
        .ram_out(ram_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r <= init_reg;
        else     r <= rin;
    end

    assign mem_out.mem_ready = r.ready;
    assign mem_out.mem_rdata = r.rdata;

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: three instances (LATENCY 2/5/3) against a word-array
// model with latency rules; honours DMEM_RESP_SEQ_EN for the fast-path expectations.
module tb_dmem_resp;
    import dmem_resp_wires::*;

    logic        clk = 1'b0;
    logic        rst [3];
    mem_in_type  mi  [3];
    mem_out_type mo  [3];

    int unsigned lat_tab   [3] = '{2, 5, 3};
    int unsigned depth_tab [3] = '{10, 6, 10};
    logic [31:0] base_tab  [3] = '{32'h0, 32'h8000, 32'h0};

    logic [31:0] model_mem [3][1024];
    bit          trk_valid [3];
    logic [31:0] trk_addr  [3];

    int unsigned cyc_now = 0;
    int          checks  = 0;
    int          errors  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_now <= cyc_now + 1;

    dmem_resp #(.DEPTH(10), .LATENCY(2), .BASE_ADDR(32'h0)) u0 (
        .clk(clk), .rst(rst[0]), .mem_in(mi[0]), .mem_out(mo[0]));
    dmem_resp #(.DEPTH(6), .LATENCY(5), .BASE_ADDR(32'h8000)) u1 (
        .clk(clk), .rst(rst[1]), .mem_in(mi[1]), .mem_out(mo[1]));
    dmem_resp #(.DEPTH(10), .LATENCY(3), .BASE_ADDR(32'h0)) u2 (
        .clk(clk), .rst(rst[2]), .mem_in(mi[2]), .mem_out(mo[2]));

    function automatic bit in_rng(input int d, input logic [31:0] a);
        longint unsigned lo, hi;
        lo = longint'(base_tab[d]);
        hi = lo + 4 * (longint'(1) << depth_tab[d]);
        return (longint'(a) >= lo) && (longint'(a) < hi);
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    task automatic invalidate_trackers();
        for (int e = 0; e < 3; e++) trk_valid[e] = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        invalidate_trackers();
    endtask

    // One request on instance d, issued in the IDLE cycle right after the previous response
    task automatic access(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input bit fence, input bit drop,
                          input string tag, output logic [31:0] rd);
        bit          rd_op, inr, seq, got;
        int unsigned lat_exp, lat_got, c0, w;
        logic [31:0] exp_rd, m;
        rd_op   = !fence && (wstrb == 4'h0);
        inr     = in_rng(d, addr);
        seq     = 1'b0;
`ifdef DMEM_RESP_SEQ_EN
        seq = rd_op && inr && trk_valid[d] && (addr == trk_addr[d] + 32'd4);
`endif
        lat_exp = (fence || seq) ? 1 : 1 + lat_tab[d];
        w       = inr ? int'((addr - base_tab[d]) >> 2) : 0;
        exp_rd  = (rd_op && inr) ? model_mem[d][w] : 32'h0;
        if (!fence && wstrb != 4'h0 && inr) begin
            m = byte_mask(wstrb);
            model_mem[d][w] = (model_mem[d][w] & ~m) | (wdata & m);
        end
        invalidate_trackers();
        trk_valid[d] = rd_op && inr;
        trk_addr[d]  = addr;

        @(posedge clk); #1;
        mi[d].mem_valid = 1'b1;
        mi[d].mem_instr = 1'($urandom);
        mi[d].mem_fence = fence;
        mi[d].mem_addr  = addr;
        mi[d].mem_wdata = wdata;
        mi[d].mem_wstrb = wstrb;
        c0      = cyc_now;
        got     = 1'b0;
        lat_got = 0;
        rd      = 32'h0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(posedge clk); #1;
            if (drop && n == 0) begin
                mi[d].mem_valid = 1'b0;
                mi[d].mem_addr  = $urandom;
                mi[d].mem_wdata = $urandom;
                mi[d].mem_wstrb = 4'($urandom);
            end
            if (mo[d].mem_ready) begin
                got     = 1'b1;
                lat_got = cyc_now - c0;
                rd      = mo[d].mem_rdata;
            end
        end
        // Address is changed in the ready cycle; the responder must not sample it
        mi[d].mem_valid = 1'b0;
        mi[d].mem_addr  = $urandom;
        mi[d].mem_wdata = $urandom;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: no ready on dut%0d addr=%h", tag, d, addr);
        end else begin
            if (lat_got !== lat_exp) begin
                errors++;
                $display("FAIL %s latency: dut%0d addr=%h got %0d expected %0d",
                         tag, d, addr, lat_got, lat_exp);
            end
            checks++;
            if (rd !== exp_rd) begin
                errors++;
                $display("FAIL %s rdata: dut%0d addr=%h got %h expected %h",
                         tag, d, addr, rd, exp_rd);
            end
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1;
            mi[d]  = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (mo[d].mem_ready !== 1'b0 || mo[d].mem_rdata !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_idle: dut%0d cycle %0d ready=%b rdata=%h expected 0/0",
                             d, n, mo[d].mem_ready, mo[d].mem_rdata);
                end
            end
        end
        invalidate_trackers();
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        access(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, "wr_deadbeef", rd);
        access(0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, "rd_deadbeef", rd);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rd_deadbeef_literal: got %h expected deadbeef", rd);
        end
    endtask

    task automatic test_byte_strobe();
        logic [31:0] rd;
        access(0, 32'h10, 32'h11223344, 4'b0101, 1'b0, 1'b1, "wr_strobe", rd);
        access(0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, "rd_strobe", rd);
        checks++;
        if (rd !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL rd_strobe_literal: got %h expected de22be44", rd);
        end
    endtask

    task automatic test_async_reset();
        bit got;
        @(posedge clk); #1;
        mi[0].mem_valid = 1'b1;
        mi[0].mem_fence = 1'b0;
        mi[0].mem_addr  = 32'h10;
        mi[0].mem_wstrb = 4'h0;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(posedge clk); #1;
            if (mo[0].mem_ready) got = 1'b1;
        end
        mi[0].mem_valid = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL async_rst_setup: no ready before reset pulse");
        end
        #2 rst[0] = 1'b1;
        #1;
        checks++;
        if (mo[0].mem_ready !== 1'b0 || mo[0].mem_rdata !== 32'h0) begin
            errors++;
            $display("FAIL async_rst: ready=%b rdata=%h expected 0/0 mid-cycle",
                     mo[0].mem_ready, mo[0].mem_rdata);
        end
        #1 rst[0] = 1'b0;
        invalidate_trackers();
    endtask

    task automatic test_fence_range();
        logic [31:0] rd;
        access(1, 32'h8000, 32'h01020304, 4'hF, 1'b0, 1'b0, "u1_wr0", rd);
        access(1, 32'h80FC, 32'hA0B0C0D0, 4'hF, 1'b0, 1'b0, "u1_wr_top", rd);
        access(1, 32'h8000, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, "fence", rd);
        access(1, 32'h8000, 32'h0, 4'h0, 1'b0, 1'b0, "after_fence", rd);
        access(1, 32'h8100, 32'h0, 4'h0, 1'b0, 1'b0, "oor_read", rd);
        access(1, 32'h8100, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0, "oor_write_hi", rd);
        access(1, 32'h7FFC, 32'hEEEEEEEE, 4'hF, 1'b0, 1'b0, "oor_write_lo", rd);
        access(1, 32'h8000, 32'h0, 4'h0, 1'b0, 1'b0, "alias_lo", rd);
        access(1, 32'h80FC, 32'h0, 4'h0, 1'b0, 1'b0, "alias_hi", rd);
        checks++;
        if (rd !== 32'hA0B0C0D0) begin
            errors++;
            $display("FAIL alias_hi_literal: got %h expected a0b0c0d0", rd);
        end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd;
        access(2, 32'h20, 32'hA5A50F0F, 4'hF, 1'b0, 1'b0, "rst_wait_pre", rd);
        @(posedge clk); #1;
        mi[2].mem_valid = 1'b1;
        mi[2].mem_fence = 1'b0;
        mi[2].mem_addr  = 32'h20;
        mi[2].mem_wdata = 32'h5A5A1234;
        mi[2].mem_wstrb = 4'hF;
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if (mo[2].mem_ready !== 1'b0) begin
                errors++;
                $display("FAIL rst_wait_early: ready=%b expected 0", mo[2].mem_ready);
            end
        end
        rst[2] = 1'b1;
        mi[2].mem_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if (mo[2].mem_ready !== 1'b0) begin
                errors++;
                $display("FAIL rst_wait_held: ready=%b expected 0", mo[2].mem_ready);
            end
        end
        rst[2] = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            checks++;
            if (mo[2].mem_ready !== 1'b0) begin
                errors++;
                $display("FAIL rst_wait_after: ready=%b expected 0", mo[2].mem_ready);
            end
        end
        invalidate_trackers();
        access(2, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0, "rst_wait_read", rd);
        checks++;
        if (rd !== 32'hA5A50F0F) begin
            errors++;
            $display("FAIL rst_wait_literal: got %h expected a5a50f0f", rd);
        end
    endtask

    task automatic test_line_refill();
        logic [31:0] rd;
        int unsigned exp_cyc [4];
        int unsigned c0;
        int          k;
`ifdef DMEM_RESP_SEQ_EN
        exp_cyc = '{4, 6, 8, 10};
`else
        exp_cyc = '{4, 9, 14, 19};
`endif
        for (int i = 0; i < 4; i++)
            access(2, 32'h40 + 32'(4 * i), $urandom, 4'hF, 1'b0, 1'b0, "refill_fill", rd);
        idle_cycles(3);
        @(posedge clk); #1;
        mi[2].mem_valid = 1'b1;
        mi[2].mem_fence = 1'b0;
        mi[2].mem_wstrb = 4'h0;
        mi[2].mem_addr  = 32'h40;
        c0 = cyc_now;
        k  = 0;
        for (int n = 0; n < 100 && k < 4; n++) begin
            @(posedge clk); #1;
            if (mo[2].mem_ready) begin
                checks++;
                if (cyc_now - c0 !== exp_cyc[k]) begin
                    errors++;
                    $display("FAIL refill_cycle%0d: got %0d expected %0d",
                             k, cyc_now - c0, exp_cyc[k]);
                end
                checks++;
                if (mo[2].mem_rdata !== model_mem[2][16 + k]) begin
                    errors++;
                    $display("FAIL refill_data%0d: got %h expected %h",
                             k, mo[2].mem_rdata, model_mem[2][16 + k]);
                end
                k++;
                if (k < 4) mi[2].mem_addr = 32'h40 + 32'(4 * k);
                else       mi[2].mem_valid = 1'b0;
            end
        end
        checks++;
        if (k != 4) begin
            errors++;
            $display("FAIL refill_timeout: got %0d beats expected 4", k);
        end
        invalidate_trackers();
        trk_valid[2] = 1'b1;
        trk_addr[2]  = 32'h4C;
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, prev;
        logic [3:0]  strb;
        bit          fence;
        int          d;
        prev = 32'h0;
        for (int i = 0; i < 60; i++) begin
            d = (i < 40) ? 0 : 1;
            if ($urandom_range(0, 7) == 0)
                addr = (base_tab[d] != 0 && $urandom_range(0, 1) == 1) ? base_tab[d] - 32'd4
                     : base_tab[d] + (32'd4 << depth_tab[d]) + 32'(4 * $urandom_range(0, 3));
            else if ($urandom_range(0, 2) == 0)
                addr = prev + 32'd4;
            else
                addr = base_tab[d] + 32'(4 * $urandom_range(0, 31));
            strb  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            fence = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) == 0) idle_cycles($urandom_range(1, 3));
            access(d, addr, $urandom, strb, fence, 1'($urandom), "random", rd);
            prev = addr;
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1;
            mi[d]  = '0;
            trk_valid[d] = 1'b0;
            trk_addr[d]  = 32'h0;
            for (int w = 0; w < 1024; w++) model_mem[d][w] = 32'h0;
        end
        test_reset();
        test_write_read();
        test_byte_strobe();
        test_async_reset();
        test_fence_range();
        test_reset_in_wait();
        test_line_refill();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
